// File: rtl/accel_bus_arbiter.sv
// rtl/accel_bus_arbiter.sv - round-robin owner arbitration for the accelerator register bus with run lock and watchdog
module accel_bus_arbiter #(
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic [1:0]        cpu_rdwr,
    input  logic [2:0]        cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_start,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_gnt,
    output logic              cpu_done,
    output logic              cpu_err,
    input  logic              ipu_req,
    input  logic [1:0]        ipu_rdwr,
    input  logic [2:0]        ipu_addr,
    input  logic [DATA_W-1:0] ipu_wdata,
    input  logic              ipu_start,
    output logic [DATA_W-1:0] ipu_rdata,
    output logic              ipu_gnt,
    output logic              ipu_done,
    output logic              ipu_err,
    output logic              acc_en,
    output logic              acc_start,
    input  logic              acc_done,
    output logic [1:0]        acc_rdwr,
    output logic [2:0]        acc_addr,
    output logic [DATA_W-1:0] acc_wdata,
    input  logic [DATA_W-1:0] acc_rdata,
    output logic              busy,
    output logic              acc_timeout
);

    localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t            state;
    logic              owner;
    logic              last;
    logic [WD_W-1:0]   wd_cnt;

    logic              own_req;
    logic              own_start;
    logic [1:0]        own_rdwr;
    logic [2:0]        own_addr;
    logic [DATA_W-1:0] own_wdata;
    logic              pick;

    // Select the current owner's request signals; pick is the IDLE winner (ipu only, or the one that did not go last)
    always_comb begin
        own_req   = owner ? ipu_req   : cpu_req;
        own_start = owner ? ipu_start : cpu_start;
        own_rdwr  = owner ? ipu_rdwr  : cpu_rdwr;
        own_addr  = owner ? ipu_addr  : cpu_addr;
        own_wdata = owner ? ipu_wdata : cpu_wdata;
        pick      = (cpu_req && ipu_req) ? ~last : ipu_req;
    end

    // Ownership FSM with registered grant, pulse and busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last        <= 1'b1;
            wd_cnt      <= '0;
            cpu_gnt     <= 1'b0;
            ipu_gnt     <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
            ipu_done    <= 1'b0;
            ipu_err     <= 1'b0;
            acc_start   <= 1'b0;
            acc_timeout <= 1'b0;
            busy        <= 1'b0;
        end else begin
            acc_start   <= 1'b0;
            acc_timeout <= 1'b0;
            cpu_done    <= 1'b0;
            cpu_err     <= 1'b0;
            ipu_done    <= 1'b0;
            ipu_err     <= 1'b0;
            case (state)
                IDLE: begin
                    if (cpu_req || ipu_req) begin
                        owner   <= pick;
                        cpu_gnt <= ~pick;
                        ipu_gnt <= pick;
                        busy    <= 1'b1;
                        state   <= OWN;
                    end
                end
                OWN: begin
                    if (own_start) begin
                        acc_start <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= RUN;
                    end else if (!own_req) begin
                        cpu_gnt <= 1'b0;
                        ipu_gnt <= 1'b0;
                        busy    <= 1'b0;
                        last    <= owner;
                        state   <= IDLE;
                    end
                end
                RUN: begin
                    if (acc_done || (wd_cnt == WD_LAST)) begin
                        if (owner) ipu_done <= 1'b1;
                        else       cpu_done <= 1'b1;
                        if (!acc_done) begin
                            if (owner) ipu_err <= 1'b1;
                            else       cpu_err <= 1'b1;
                            acc_timeout <= 1'b1;
                        end
                        if (acc_done && own_req) begin
                            state <= OWN;
                        end else begin
                            cpu_gnt <= 1'b0;
                            ipu_gnt <= 1'b0;
                            busy    <= 1'b0;
                            last    <= owner;
                            state   <= IDLE;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Combinational forwarding: only the owner reaches the accelerator, and only while in OWN
    always_comb begin
        acc_en    = (state != IDLE);
        acc_rdwr  = 2'b00;
        acc_addr  = 3'd0;
        acc_wdata = '0;
        cpu_rdata = '0;
        ipu_rdata = '0;
        if (state == OWN) begin
            acc_rdwr  = (own_rdwr == 2'b11) ? 2'b00 : own_rdwr;
            acc_addr  = own_addr;
            acc_wdata = own_wdata;
            if (owner) ipu_rdata = acc_rdata;
            else       cpu_rdata = acc_rdata;
        end
    end

endmodule

// File: tb/tb_accel_bus_arbiter.sv
// tb/tb_accel_bus_arbiter.sv - table-driven and sequence checks for accel_bus_arbiter
module tb_accel_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_req, cpu_start, ipu_req, ipu_start, acc_done;
    logic [1:0]  cpu_rdwr, ipu_rdwr;
    logic [2:0]  cpu_addr, ipu_addr;
    logic [15:0] cpu_wdata, ipu_wdata, acc_rdata;
    logic [15:0] cpu_rdata, ipu_rdata, acc_wdata;
    logic        cpu_gnt, cpu_done, cpu_err, ipu_gnt, ipu_done, ipu_err;
    logic        acc_en, acc_start, busy, acc_timeout;
    logic [1:0]  acc_rdwr;
    logic [2:0]  acc_addr;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    accel_bus_arbiter #(.DATA_W(16), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_rdwr(cpu_rdwr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_start(cpu_start), .cpu_rdata(cpu_rdata), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_err(cpu_err),
        .ipu_req(ipu_req), .ipu_rdwr(ipu_rdwr), .ipu_addr(ipu_addr), .ipu_wdata(ipu_wdata),
        .ipu_start(ipu_start), .ipu_rdata(ipu_rdata), .ipu_gnt(ipu_gnt), .ipu_done(ipu_done), .ipu_err(ipu_err),
        .acc_en(acc_en), .acc_start(acc_start), .acc_done(acc_done), .acc_rdwr(acc_rdwr),
        .acc_addr(acc_addr), .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
        .busy(busy), .acc_timeout(acc_timeout)
    );

    typedef struct {
        logic cr; logic [1:0] crw; logic [2:0] ca; logic [15:0] cwd; logic cs;
        logic ir; logic [1:0] irw; logic [2:0] ia; logic [15:0] iwd; logic is;
        logic ad; logic [15:0] ard;
        logic cg; logic ig; logic en; logic st; logic [1:0] rw; logic [2:0] a; logic [15:0] wd;
        logic [15:0] crd; logic [15:0] ird; logic cd; logic ce; logic id; logic ie; logic bz; logic to;
    } vec_t;

    vec_t vecs[21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        cpu_req = 0; cpu_rdwr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_start = 0;
        ipu_req = 0; ipu_rdwr = 0; ipu_addr = 0; ipu_wdata = 0; ipu_start = 0;
        acc_done = 0; acc_rdata = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        //          cpu: req rdwr addr wdata start | ipu: req rdwr addr wdata start | done rdata || cg ig en st rw a wd crd ird cd ce id ie bz to
        vecs[0]  = '{0,0,0,0,0,        0,0,0,0,0,        0,'h1234, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[1]  = '{1,1,3,'hBEEF,0,   0,0,0,0,0,        0,'h1234, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[2]  = '{1,1,3,'hBEEF,0,   0,0,0,0,0,        0,'h1234, 1,0,1,0,1,3,'hBEEF,'h1234,0,0,0,0,0,1,0};
        vecs[3]  = '{1,2,3,0,0,        1,1,5,'h5555,1,   0,'h1234, 1,0,1,0,2,3,0,'h1234,0,0,0,0,0,1,0};
        vecs[4]  = '{1,3,2,'h00AA,0,   1,0,0,0,0,        0,'h1234, 1,0,1,0,0,2,'h00AA,'h1234,0,0,0,0,0,1,0};
        vecs[5]  = '{0,0,0,0,0,        1,0,0,0,0,        0,'h1234, 1,0,1,0,0,0,0,'h1234,0,0,0,0,0,1,0};
        vecs[6]  = '{0,0,0,0,0,        1,0,0,0,0,        0,'h1234, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[7]  = '{0,0,0,0,0,        1,1,4,'h0F0F,0,   0,'h4321, 0,1,1,0,1,4,'h0F0F,0,'h4321,0,0,0,0,1,0};
        vecs[8]  = '{0,0,0,0,0,        1,1,4,'h0F0F,1,   0,'h4321, 0,1,1,0,1,4,'h0F0F,0,'h4321,0,0,0,0,1,0};
        vecs[9]  = '{0,0,0,0,0,        1,1,4,'h0F0F,0,   0,0,      0,1,1,1,0,0,0,0,0,0,0,0,0,1,0};
        vecs[10] = '{0,0,0,0,0,        1,1,4,'h0F0F,0,   0,0,      0,1,1,0,0,0,0,0,0,0,0,0,0,1,0};
        vecs[11] = '{0,0,0,0,0,        1,1,4,'h0F0F,0,   1,0,      0,1,1,0,0,0,0,0,0,0,0,0,0,1,0};
        vecs[12] = '{1,0,0,0,0,        1,2,1,0,0,        0,'h7777, 0,1,1,0,2,1,0,0,'h7777,0,0,1,0,1,0};
        vecs[13] = '{1,0,0,0,0,        0,0,0,0,0,        0,'h7777, 0,1,1,0,0,0,0,0,'h7777,0,0,0,0,1,0};
        vecs[14] = '{1,0,0,0,0,        1,0,0,0,0,        0,'h7777, 0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[15] = '{1,0,0,0,0,        1,0,0,0,0,        0,0,      1,0,1,0,0,0,0,0,0,0,0,0,0,1,0};
        vecs[16] = '{0,0,0,0,0,        1,0,0,0,0,        0,0,      1,0,1,0,0,0,0,0,0,0,0,0,0,1,0};
        vecs[17] = '{0,0,0,0,0,        1,0,0,0,0,        0,0,      0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};
        vecs[18] = '{1,0,0,0,0,        1,0,0,0,0,        0,0,      0,1,1,0,0,0,0,0,0,0,0,0,0,1,0};
        vecs[19] = '{0,0,0,0,0,        0,0,0,0,0,        0,0,      0,1,1,0,0,0,0,0,0,0,0,0,0,1,0};
        vecs[20] = '{0,0,0,0,0,        0,0,0,0,0,        0,0,      0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

        clr_in();
        rst_n = 0;
        tick();
        tick();
        rst_n = 1;

        for (int i = 0; i < 21; i++) begin
            cpu_req = vecs[i].cr; cpu_rdwr = vecs[i].crw; cpu_addr = vecs[i].ca;
            cpu_wdata = vecs[i].cwd; cpu_start = vecs[i].cs;
            ipu_req = vecs[i].ir; ipu_rdwr = vecs[i].irw; ipu_addr = vecs[i].ia;
            ipu_wdata = vecs[i].iwd; ipu_start = vecs[i].is;
            acc_done = vecs[i].ad; acc_rdata = vecs[i].ard;
            #1;
            chk($sformatf("row%0d cpu_gnt", i), 32'(cpu_gnt), 32'(vecs[i].cg));
            chk($sformatf("row%0d ipu_gnt", i), 32'(ipu_gnt), 32'(vecs[i].ig));
            chk($sformatf("row%0d acc_en", i), 32'(acc_en), 32'(vecs[i].en));
            chk($sformatf("row%0d acc_start", i), 32'(acc_start), 32'(vecs[i].st));
            chk($sformatf("row%0d acc_rdwr", i), 32'(acc_rdwr), 32'(vecs[i].rw));
            chk($sformatf("row%0d acc_addr", i), 32'(acc_addr), 32'(vecs[i].a));
            chk($sformatf("row%0d acc_wdata", i), 32'(acc_wdata), 32'(vecs[i].wd));
            chk($sformatf("row%0d cpu_rdata", i), 32'(cpu_rdata), 32'(vecs[i].crd));
            chk($sformatf("row%0d ipu_rdata", i), 32'(ipu_rdata), 32'(vecs[i].ird));
            chk($sformatf("row%0d cpu_done", i), 32'(cpu_done), 32'(vecs[i].cd));
            chk($sformatf("row%0d cpu_err", i), 32'(cpu_err), 32'(vecs[i].ce));
            chk($sformatf("row%0d ipu_done", i), 32'(ipu_done), 32'(vecs[i].id));
            chk($sformatf("row%0d ipu_err", i), 32'(ipu_err), 32'(vecs[i].ie));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].bz));
            chk($sformatf("row%0d acc_timeout", i), 32'(acc_timeout), 32'(vecs[i].to));
            tick();
        end

        // start coincident with req drop still enters RUN
        clr_in();
        cpu_req = 1;
        tick();
        cpu_req = 0; cpu_start = 1;
        tick();
        chk("start_drop acc_start", 32'(acc_start), 32'd1);
        chk("start_drop cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("start_drop busy", 32'(busy), 32'd1);
        cpu_start = 0;
        tick();
        chk("start_drop still_run acc_en", 32'(acc_en), 32'd1);
        chk("start_drop acc_start_once", 32'(acc_start), 32'd0);
        acc_done = 1;
        tick();
        acc_done = 0;
        chk("start_drop cpu_done", 32'(cpu_done), 32'd1);
        chk("start_drop cpu_err", 32'(cpu_err), 32'd0);
        chk("start_drop released gnt", 32'(cpu_gnt), 32'd0);
        chk("start_drop released acc_en", 32'(acc_en), 32'd0);
        tick();
        chk("start_drop done_once", 32'(cpu_done), 32'd0);

        // watchdog abort TIMEOUT cycles after RUN entry
        cpu_req = 1;
        tick();
        cpu_start = 1;
        tick();
        cpu_start = 0;
        for (int k = 1; k < 8; k++) begin
            tick();
            chk($sformatf("wd early%0d acc_timeout", k), 32'(acc_timeout), 32'd0);
            chk($sformatf("wd early%0d acc_en", k), 32'(acc_en), 32'd1);
        end
        tick();
        chk("wd acc_timeout", 32'(acc_timeout), 32'd1);
        chk("wd cpu_done", 32'(cpu_done), 32'd1);
        chk("wd cpu_err", 32'(cpu_err), 32'd1);
        chk("wd acc_en", 32'(acc_en), 32'd0);
        chk("wd cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("wd busy", 32'(busy), 32'd0);
        cpu_req = 0;
        tick();
        chk("wd timeout_once", 32'(acc_timeout), 32'd0);
        chk("wd err_once", 32'(cpu_err), 32'd0);

        // acc_done on the timeout cycle wins: no error, stays owned
        cpu_req = 1;
        tick();
        cpu_start = 1;
        tick();
        cpu_start = 0;
        for (int k = 1; k < 8; k++) tick();
        acc_done = 1;
        tick();
        acc_done = 0;
        chk("tie cpu_done", 32'(cpu_done), 32'd1);
        chk("tie cpu_err", 32'(cpu_err), 32'd0);
        chk("tie acc_timeout", 32'(acc_timeout), 32'd0);
        chk("tie cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("tie acc_en", 32'(acc_en), 32'd1);
        cpu_req = 0;
        tick();

        // asynchronous reset during RUN, then cpu wins first contention
        cpu_req = 1;
        tick();
        cpu_start = 1;
        tick();
        cpu_start = 0;
        tick();
        tick();
        chk("rst pre acc_en", 32'(acc_en), 32'd1);
        rst_n = 0;
        #1;
        chk("rst async acc_en", 32'(acc_en), 32'd0);
        chk("rst async cpu_gnt", 32'(cpu_gnt), 32'd0);
        chk("rst async busy", 32'(busy), 32'd0);
        chk("rst async acc_start", 32'(acc_start), 32'd0);
        ipu_req = 1;
        tick();
        chk("rst no cpu_done", 32'(cpu_done), 32'd0);
        chk("rst held cpu_gnt", 32'(cpu_gnt), 32'd0);
        rst_n = 1;
        tick();
        chk("rst first cpu_gnt", 32'(cpu_gnt), 32'd1);
        chk("rst first ipu_gnt", 32'(ipu_gnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
